latch_sr_controller: RTL
========================

Name: latch_sr_controller

Overview:
- Sequencer and arbiter for a bank of WIDTH gated SR latches (enable/set/reset in, out/notout back).
- Two requesters issue SET, RESET, TOGGLE or HOLD commands on one latch index each.
- The controller grants requesters round-robin and drives setup, enable pulse and hold phases. It never drives set and reset together, then checks the latch readback and acknowledges.

Parameters:
- WIDTH, 4, number of latches in the bank (>= 2)
- IDXW, 2, index width, = clog2(WIDTH)
- PULSE_CYCLES, 2, cycles latch_enable stays high per write (>= 1)

Ports:
- cp  in  1  clock, rising-edge
- notreset  in  1  asynchronous active-low reset
- req_a  in  1  requester A command request, level, held until ack_a
- op_a  in  2  A opcode: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
- idx_a  in  IDXW  A latch index
- ack_a  out  1  one-cycle completion strobe to A
- req_b / op_b / idx_b / ack_b  as above, requester B
- fault  out  1  transaction status, valid only while ack_a or ack_b is high
- busy  out  1  high in every state except IDLE
- latch_enable  out  WIDTH  one-hot gate enable to the bank
- latch_set  out  1  shared set line
- latch_reset  out  1  shared reset line
- latch_out  in  WIDTH  bank Q readback
- latch_notout  in  WIDTH  bank notQ readback

Behaviour:
- Reset (notreset=0, asynchronous): state=IDLE. All outputs are 0, including ack_a, ack_b, fault, busy, latch_enable, latch_set and latch_reset. last_grant=B, so A wins the first tie. Any in-flight transaction is dropped with no ack.
- States: IDLE, SETUP, PULSE, HOLD, CHECK. All outputs are registered.
- IDLE: at each edge, sample req_a/req_b.
  - With one request, grant that requester; with both, grant the requester opposite to last_grant; then update last_grant.
  - Capture op, idx and the current bit cur=latch_out[idx].
  - Resolve the opcode: TOGGLE becomes SET if cur=0, otherwise RESET. Expected value exp = 1 for SET, 0 for RESET, cur for HOLD.
  - HOLD opcode, or idx >= WIDTH: go directly to CHECK. For idx >= WIDTH, force fault=1.
  - Otherwise go to SETUP.
- SETUP (1 cycle): drive exactly one of latch_set/latch_reset high; latch_enable=0.
- PULSE (PULSE_CYCLES cycles): latch_enable[idx]=1, all other enable bits 0; set/reset unchanged. A down-counter times the phase.
- HOLD (1 cycle): latch_enable=0; set/reset still driven (data hold time).
- CHECK (1 cycle):
  - set/reset=0.
  - ack of the granted requester=1.
  - fault=1 if latch_out[idx]!=exp, or latch_out[idx]==latch_notout[idx], or idx out of range.
  - Next state IDLE.
- Latency from acceptance edge k to ack high: edge k+PULSE_CYCLES+3 for writes (k+5 at default PULSE_CYCLES=2); edge k+1 for HOLD or invalid index.
- IDLE lasts at least 1 cycle, so back-to-back grants are spaced by at least one idle cycle. A requester must drop req in the cycle after its ack; a req still high in IDLE is taken as a new command.
- Invariants: latch_set & latch_reset == 0 always; popcount(latch_enable) <= 1 always; latch_enable is nonzero only in PULSE.
- Opcode/index changes while a transaction is in flight are ignored, because they were captured at the grant.
- The losing requester waits without an ack and is granted on the next IDLE evaluation.

Decomposition:
- Shared package latch_ctrl_pkg holds:
  - op encodings (OP_HOLD, OP_RESET, OP_SET, OP_TOGGLE)
  - the state enum
  - default PULSE_CYCLES
- One sub-module, rr_arbiter2: a 2-requester round-robin arbiter with a last_grant register and an update strobe driven in IDLE. Everything else is in latch_sr_controller.

Test Plan:
- Reset, then req_a=1, op_a=SET, idx_a=2, with the bank model latching correctly:
  - latch_set=1 at SETUP
  - latch_enable=0100 for 2 cycles
  - ack_a high 5 edges after acceptance, fault=0
- req_a and req_b both high from reset (A RESET idx 0, B SET idx 1): A is served first and B next; then, with both re-requesting, A is served after B (alternation).
- TOGGLE on idx 3 with latch_out[3]=1: latch_reset=1, never latch_set; ack with fault=0 once latch_out[3]=0.
- Bank model forces latch_out[1]=latch_notout[1]=1 (forbidden state) with a SET on idx 1: ack with fault=1.
- HOLD on idx 0: no enable pulse; ack 1 edge after acceptance; fault=0.
- notreset pulsed low mid-PULSE: latch_enable, set and reset go to 0 immediately; no ack; next request is serviced normally.
- Assertions enabled throughout: set&reset never both 1; latch_enable at most one-hot.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
// Shared opcode encodings, FSM state type and defaults for the SR latch bank controller.
package latch_ctrl_pkg;

   localparam logic [1:0] OP_HOLD   = 2'b00;
   localparam logic [1:0] OP_RESET  = 2'b01;
   localparam logic [1:0] OP_SET    = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   localparam int DEF_PULSE_CYCLES = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_CHECK
   } state_e;

   // Only HOLD leaves the latch untouched; everything else is a write.
   function automatic logic op_is_write(input logic [1:0] op);
      return op != OP_HOLD;
   endfunction

   // Value the latch must hold after the command; TOGGLE resolves against the bit seen at grant.
   function automatic logic op_expected(input logic [1:0] op, input logic cur);
      logic exp;
      unique case (op)
         OP_RESET:  exp = 1'b0;
         OP_SET:    exp = 1'b1;
         OP_TOGGLE: exp = ~cur;
         default:   exp = cur;
      endcase
      return exp;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the last grant only moves when the owner strobes update.
module rr_arbiter2 (
   input  logic cp,
   input  logic notreset,
   input  logic req_a,
   input  logic req_b,
   input  logic update,
   output logic gnt_valid,
   output logic gnt_b
);

   logic last_b_q;
   logic last_b_d;

   // Grant decision: a tie goes to whoever was not served last.
   always_comb begin
      gnt_valid = req_a | req_b;
      gnt_b     = req_b & (~req_a | ~last_b_q);
      last_b_d  = update ? gnt_b : last_b_q;
   end

   // Last-grant register; resets to B so A wins the first tie.
   always_ff @(posedge cp or negedge notreset) begin
      if (!notreset) last_b_q <= 1'b1;
      else           last_b_q <= last_b_d;
   end

endmodule

// File: rtl/latch_sr_controller.sv
// Sequencer for a bank of gated SR latches: arbitrates two requesters, drives
// setup / enable pulse / hold phases on the shared set/reset lines, then
// verifies the readback and acknowledges with a fault status.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting; samples requests and captures op/idx/current bit
// ST_SETUP | set or reset line driven, enable low (data setup)
// ST_PULSE | enable bit of the target latch high for PULSE_CYCLES cycles
// ST_HOLD  | enable low, set/reset still driven (data hold)
// ST_CHECK | lines released; readback compared, ack + fault registered
module latch_sr_controller
   import latch_ctrl_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int IDXW         = 2,
   parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
   input  logic             cp,
   input  logic             notreset,
   input  logic             req_a,
   input  logic [1:0]       op_a,
   input  logic [IDXW-1:0]  idx_a,
   output logic             ack_a,
   input  logic             req_b,
   input  logic [1:0]       op_b,
   input  logic [IDXW-1:0]  idx_b,
   output logic             ack_b,
   output logic             fault,
   output logic             busy,
   output logic [WIDTH-1:0] latch_enable,
   output logic             latch_set,
   output logic             latch_reset,
   input  logic [WIDTH-1:0] latch_out,
   input  logic [WIDTH-1:0] latch_notout
);

   localparam int CNTW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

   state_e            state_q, state_d;
   logic              gnt_b_q, gnt_b_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              exp_q, exp_d;
   logic              bad_idx_q, bad_idx_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  en_q, en_d;
   logic              set_q, set_d;
   logic              rst_q, rst_d;
   logic              ack_a_q, ack_a_d;
   logic              ack_b_q, ack_b_d;
   logic              fault_q, fault_d;
   logic              busy_q, busy_d;

   logic              arb_valid;
   logic              arb_gnt_b;
   logic              arb_update;

   logic [1:0]        sel_op;
   logic [IDXW-1:0]   sel_idx;
   logic              sel_in_range;
   logic              sel_cur;
   logic              chk_in_range;
   logic              chk_q_bit;
   logic              chk_nq_bit;

   rr_arbiter2 u_arb (
      .cp        (cp),
      .notreset  (notreset),
      .req_a     (req_a),
      .req_b     (req_b),
      .update    (arb_update),
      .gnt_valid (arb_valid),
      .gnt_b     (arb_gnt_b)
   );

   // Next-state and next-output logic; outputs are computed for the state being entered.
   always_comb begin
      state_d    = state_q;
      gnt_b_d    = gnt_b_q;
      idx_d      = idx_q;
      exp_d      = exp_q;
      bad_idx_d  = bad_idx_q;
      cnt_d      = cnt_q;
      en_d       = '0;
      set_d      = 1'b0;
      rst_d      = 1'b0;
      ack_a_d    = 1'b0;
      ack_b_d    = 1'b0;
      fault_d    = 1'b0;
      arb_update = 1'b0;

      sel_op       = arb_gnt_b ? op_b : op_a;
      sel_idx      = arb_gnt_b ? idx_b : idx_a;
      sel_in_range = int'(sel_idx) < WIDTH;
      sel_cur      = sel_in_range ? latch_out[sel_idx] : 1'b0;
      chk_in_range = int'(idx_q) < WIDTH;
      chk_q_bit    = chk_in_range ? latch_out[idx_q] : 1'b0;
      chk_nq_bit   = chk_in_range ? latch_notout[idx_q] : 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               arb_update = 1'b1;
               gnt_b_d    = arb_gnt_b;
               idx_d      = sel_idx;
               exp_d      = op_expected(sel_op, sel_cur);
               bad_idx_d  = ~sel_in_range;
               if (!op_is_write(sel_op) || !sel_in_range) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_SETUP;
                  set_d   = exp_d;
                  rst_d   = ~exp_d;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_PULSE;
            cnt_d   = CNTW'(PULSE_CYCLES - 1);
            en_d    = WIDTH'(1) << idx_q;
            set_d   = exp_q;
            rst_d   = ~exp_q;
         end
         ST_PULSE: begin
            set_d = exp_q;
            rst_d = ~exp_q;
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
               en_d  = WIDTH'(1) << idx_q;
            end
         end
         ST_HOLD: begin
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
            ack_a_d = ~gnt_b_q;
            ack_b_d = gnt_b_q;
            fault_d = bad_idx_q | (chk_q_bit != exp_q) | (chk_q_bit == chk_nq_bit);
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, captured transaction and registered outputs; reset drops any transaction.
   always_ff @(posedge cp or negedge notreset) begin
      if (!notreset) begin
         state_q   <= ST_IDLE;
         gnt_b_q   <= 1'b0;
         idx_q     <= '0;
         exp_q     <= 1'b0;
         bad_idx_q <= 1'b0;
         cnt_q     <= '0;
         en_q      <= '0;
         set_q     <= 1'b0;
         rst_q     <= 1'b0;
         ack_a_q   <= 1'b0;
         ack_b_q   <= 1'b0;
         fault_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_b_q   <= gnt_b_d;
         idx_q     <= idx_d;
         exp_q     <= exp_d;
         bad_idx_q <= bad_idx_d;
         cnt_q     <= cnt_d;
         en_q      <= en_d;
         set_q     <= set_d;
         rst_q     <= rst_d;
         ack_a_q   <= ack_a_d;
         ack_b_q   <= ack_b_d;
         fault_q   <= fault_d;
         busy_q    <= busy_d;
      end
   end

   assign ack_a        = ack_a_q;
   assign ack_b        = ack_b_q;
   assign fault        = fault_q;
   assign busy         = busy_q;
   assign latch_enable = en_q;
   assign latch_set    = set_q;
   assign latch_reset  = rst_q;

endmodule
